// File: rtl/alu_exec_pkg.sv
// Shared constants for the EX-stage ALU: control codes, FSM states, default width.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package alu_exec_pkg;

  localparam int DATA_W_DEF = 32;

  localparam logic [5:0] OP_AND   = 6'd0;
  localparam logic [5:0] OP_OR    = 6'd1;
  localparam logic [5:0] OP_ADD   = 6'd2;
  localparam logic [5:0] OP_LUI   = 6'd3;
  localparam logic [5:0] OP_SRL   = 6'd4;
  localparam logic [5:0] OP_SRLV  = 6'd5;
  localparam logic [5:0] OP_SUB   = 6'd6;
  localparam logic [5:0] OP_SLT   = 6'd7;
  localparam logic [5:0] OP_ORI   = 6'd8;
  localparam logic [5:0] OP_SLTIU = 6'd9;
  localparam logic [5:0] OP_MUL   = 6'd10;
  localparam logic [5:0] OP_BGEZ  = 6'd11;
  localparam logic [5:0] OP_BGT   = 6'd13;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_t;

endpackage

// File: rtl/alu_mul_seq.sv
// Iterative unsigned shift-add multiplier, low DATA_W bits of the product.
// Latency: DATA_W step cycles after load; prod is the final value while last=1.
// Backpressure: none; the caller must hold step high for DATA_W cycles.
module alu_mul_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              load,
  input  logic              step,
  input  logic [DATA_W-1:0] src1,
  input  logic [DATA_W-1:0] src2,
  output logic              last,
  output logic [DATA_W-1:0] prod
);

  localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  logic [DATA_W-1:0] mcand;
  logic [DATA_W-1:0] mplier;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  // Accumulator value after the current iteration; valid as the product on the last one.
  always_comb begin
    prod = acc + (mplier[0] ? mcand : '0);
    last = step && (cnt == CNT_W'(DATA_W - 1));
  end

  // Load operands on issue, then shift multiplicand left / multiplier right each step.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
    end else if (load) begin
      mcand  <= src1;
      mplier <= src2;
      acc    <= '0;
      cnt    <= '0;
    end else if (step) begin
      acc    <= prod;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
      cnt    <= last ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/alu_exec.sv
// EX-stage ALU: single-cycle ops plus optional iterative MUL (enabled by ALU_EXEC_MUL_EN).
// Latency: single-cycle ops registered at the accepting edge; MUL completes DATA_W edges later.
// Backpressure: ready_o low while MUL runs; start_i is ignored (not queued) while not ready.
module alu_exec
  import alu_exec_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              start_i,
  input  logic [5:0]        ctrl_i,
  input  logic [DATA_W-1:0] src1_i,
  input  logic [DATA_W-1:0] src2_i,
  input  logic [4:0]        shamt_i,
  output logic              ready_o,
  output logic              valid_o,
  output logic [DATA_W-1:0] result_o,
  output logic              zero_o,
  output logic              branch_o,
  output logic              illegal_o
);

  logic [DATA_W-1:0] alu_res;
  logic              alu_br;
  logic              alu_ill;
  logic              is_mul;
  logic              accept_single;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;

  // Single-cycle datapath; code 10 falls to illegal here and is diverted when MUL exists.
  always_comb begin
    alu_res = '0;
    alu_br  = 1'b0;
    alu_ill = 1'b0;
    case (ctrl_i)
      OP_AND:   alu_res = src1_i & src2_i;
      OP_OR:    alu_res = src1_i | src2_i;
      OP_ADD:   alu_res = src1_i + src2_i;
      OP_LUI:   alu_res = DATA_W'(src2_i[15:0]) << 16;
      OP_SRL:   alu_res = src2_i >> shamt_i;
      OP_SRLV:  alu_res = src2_i >> src1_i[4:0];
      OP_SUB: begin
        alu_res = src1_i - src2_i;
        alu_br  = (alu_res == '0);
      end
      OP_SLT:   alu_res = DATA_W'($signed(src1_i) < $signed(src2_i));
      OP_ORI:   alu_res = src1_i | DATA_W'(src2_i[15:0]);
      OP_SLTIU: alu_res = DATA_W'(src1_i < src2_i);
      OP_BGEZ:  alu_br  = ~src1_i[DATA_W-1];
      OP_BGT:   alu_br  = ($signed(src1_i) > $signed(src2_i));
      default:  alu_ill = 1'b1;
    endcase
  end

`ifdef ALU_EXEC_MUL_EN
  state_t state;
  state_t state_nxt;
  logic   mul_load;
  logic   mul_step;
  logic   mul_last;

  assign is_mul   = (ctrl_i == OP_MUL);
  assign mul_done = mul_last;

  // State register.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and engine control: IDLE accepts, MUL steps until the last iteration.
  always_comb begin
    state_nxt = state;
    ready_o   = 1'b0;
    mul_load  = 1'b0;
    mul_step  = 1'b0;
    case (state)
      ST_IDLE: begin
        ready_o = 1'b1;
        if (start_i && is_mul) begin
          mul_load  = 1'b1;
          state_nxt = ST_MUL;
        end
      end
      ST_MUL: begin
        mul_step = 1'b1;
        if (mul_last) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  alu_mul_seq #(.DATA_W(DATA_W)) u_mul (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .load  (mul_load),
    .step  (mul_step),
    .src1  (src1_i),
    .src2  (src2_i),
    .last  (mul_last),
    .prod  (mul_prod)
  );
`else
  assign ready_o  = 1'b1;
  assign is_mul   = 1'b0;
  assign mul_done = 1'b0;
  assign mul_prod = '0;
`endif

  assign accept_single = start_i && ready_o && !is_mul;

  // Output registers: load on a single-cycle accept or MUL completion, otherwise hold.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      valid_o   <= 1'b0;
      result_o  <= '0;
      zero_o    <= 1'b0;
      branch_o  <= 1'b0;
      illegal_o <= 1'b0;
    end else begin
      valid_o <= 1'b0;
      if (accept_single) begin
        valid_o   <= 1'b1;
        result_o  <= alu_res;
        zero_o    <= (alu_res == '0);
        branch_o  <= alu_br;
        illegal_o <= alu_ill;
      end else if (mul_done) begin
        valid_o   <= 1'b1;
        result_o  <= mul_prod;
        zero_o    <= (mul_prod == '0);
        branch_o  <= 1'b0;
        illegal_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_exec.sv
// Self-checking bench for alu_exec: behavioural model plus directed literal checks.
// Model works from operation semantics (countdown for MUL busy time, native multiply).
// Works with ALU_EXEC_MUL_EN defined or undefined.
module tb_alu_exec;

  localparam int W = 32;
`ifdef ALU_EXEC_MUL_EN
  localparam bit MUL_EN = 1'b1;
`else
  localparam bit MUL_EN = 1'b0;
`endif

  logic         clk_i   = 1'b0;
  logic         rst_i   = 1'b0;
  logic         start_i = 1'b0;
  logic [5:0]   ctrl_i  = '0;
  logic [W-1:0] src1_i  = '0;
  logic [W-1:0] src2_i  = '0;
  logic [4:0]   shamt_i = '0;
  logic         ready_o, valid_o, zero_o, branch_o, illegal_o;
  logic [W-1:0] result_o;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk_i = ~clk_i;

  alu_exec #(.DATA_W(W)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .start_i  (start_i),
    .ctrl_i   (ctrl_i),
    .src1_i   (src1_i),
    .src2_i   (src2_i),
    .shamt_i  (shamt_i),
    .ready_o  (ready_o),
    .valid_o  (valid_o),
    .result_o (result_o),
    .zero_o   (zero_o),
    .branch_o (branch_o),
    .illegal_o(illegal_o)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference semantics of the single-cycle codes.
  function automatic void alu_ref(input logic [5:0] c, input logic [W-1:0] a, input logic [W-1:0] b,
                                  input logic [4:0] sh, output logic [W-1:0] r, output logic br,
                                  output logic ill);
    r = 0; br = 0; ill = 0;
    case (c)
      6'd0:  r = a & b;
      6'd1:  r = a | b;
      6'd2:  r = a + b;
      6'd3:  r = {b[15:0], 16'h0000};
      6'd4:  r = b >> sh;
      6'd5:  r = b >> a[4:0];
      6'd6:  begin r = a - b; br = (a == b); end
      6'd7:  r = ($signed(a) < $signed(b)) ? 1 : 0;
      6'd8:  r = a | {16'h0000, b[15:0]};
      6'd9:  r = (a < b) ? 1 : 0;
      6'd11: br = ($signed(a) >= 0);
      6'd13: br = ($signed(a) > $signed(b));
      default: ill = 1;
    endcase
  endfunction

  // Behavioural model: expected outputs after each edge.
  logic         m_ready = 1, m_valid = 0, m_zero = 0, m_br = 0, m_ill = 0;
  logic [W-1:0] m_res = 0, m_pend = 0;
  int           m_busy = 0;

  always @(posedge clk_i or negedge rst_i) begin
    logic [W-1:0] r;
    logic         b, il;
    if (!rst_i) begin
      m_ready = 1; m_valid = 0; m_zero = 0; m_br = 0; m_ill = 0; m_res = 0; m_busy = 0;
    end else begin
      m_valid = 0;
      if (m_busy > 0) begin
        m_busy--;
        if (m_busy == 0) begin
          m_valid = 1; m_res = m_pend; m_zero = (m_pend == 0); m_br = 0; m_ill = 0;
        end
      end else if (start_i) begin
        if (MUL_EN && ctrl_i == 6'd10) begin
          m_busy = W;
          m_pend = src1_i * src2_i;
        end else begin
          alu_ref(ctrl_i, src1_i, src2_i, shamt_i, r, b, il);
          m_valid = 1; m_res = r; m_zero = (r == 0); m_br = b; m_ill = il;
        end
      end
      m_ready = (m_busy == 0);
    end
  end

  // Compare every cycle on the falling edge.
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("ready",  ready_o,  m_ready);
      chk("valid",  valid_o,  m_valid);
      chk("result", result_o, m_res);
      chk("flags",  {zero_o, branch_o, illegal_o}, {m_zero, m_br, m_ill});
    end
  end

  task automatic drive(input logic s, input logic [5:0] c, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [4:0] sh);
    start_i = s; ctrl_i = c; src1_i = a; src2_i = b; shamt_i = sh;
  endtask

  function automatic logic [W-1:0] rnd_op();
    case ($urandom_range(0, 7))
      0: return 0;
      1: return 1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    int nlow, nv;
    @(posedge clk_i);
    chk_en = 1;
    repeat (2) @(negedge clk_i);
    chk("rst_ready", ready_o, 1);
    chk("rst_valid", valid_o, 0);
    chk("rst_result", result_o, 0);
    chk("rst_flags", {zero_o, branch_o, illegal_o}, 3'b000);
    #1 rst_i = 1;

    // ADD wraps into the sign bit
    drive(1, 6'd2, 32'h7FFF_FFFF, 32'h1, 0);
    @(negedge clk_i);
    chk("add_valid", valid_o, 1);
    chk("add_res", result_o, 32'h8000_0000);
    chk("add_zero", zero_o, 0);
    // SUB then SLT back to back
    #1 drive(1, 6'd6, 5, 5, 0);
    @(negedge clk_i);
    chk("sub_res", result_o, 0);
    chk("sub_zero_br", {valid_o, zero_o, branch_o}, 3'b111);
    #1 drive(1, 6'd7, 32'hFFFF_FFFF, 1, 0);
    @(negedge clk_i);
    chk("slt_valid", valid_o, 1);
    chk("slt_res", result_o, 1);
    // Illegal code 12
    #1 drive(1, 6'd12, 32'h1234, 32'h5678, 3);
    @(negedge clk_i);
    chk("ill12", {valid_o, illegal_o, branch_o}, 3'b110);
    chk("ill12_res", result_o, 0);
    // Branches
    #1 drive(1, 6'd11, 0, 7, 0);
    @(negedge clk_i);
    chk("bgez0", branch_o, 1);
    #1 drive(1, 6'd13, 32'hFFFF_FFFD, 32'hFFFF_FFFC, 0);
    @(negedge clk_i);
    chk("bgt_m3_m4", branch_o, 1);
    #1 drive(1, 6'd13, 2, 2, 0);
    @(negedge clk_i);
    chk("bgt_2_2", {valid_o, branch_o}, 2'b10);
    #1 drive(0, 0, 0, 0, 0);
    @(negedge clk_i);

    // MUL (or illegal code 10 when the multiplier is absent)
    #1 drive(1, 6'd10, 32'h0000_FFFF, 32'h0001_0001, 0);
`ifdef ALU_EXEC_MUL_EN
    nlow = 0; nv = 0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk_i);
      if (!ready_o) nlow++;
      if (valid_o) nv++;
      #1 drive((i < 31) ? 1'($urandom_range(0, 1)) : 1'b0, 6'($urandom_range(0, 13)),
               $urandom, $urandom, 5'($urandom));
    end
    chk("mul_ready_low", nlow, 32);
    chk("mul_busy_valid", nv, 0);
    @(negedge clk_i);
    chk("mul_done", {ready_o, valid_o, illegal_o}, 3'b110);
    chk("mul_res", result_o, 32'hFFFF_FFFF);
`else
    @(negedge clk_i);
    chk("mul10_ill", {ready_o, valid_o, illegal_o}, 3'b111);
    chk("mul10_res", result_o, 0);
`endif
    #1 drive(0, 0, 0, 0, 0);
    @(negedge clk_i);

    // Reset in the middle of a MUL
    #1 drive(1, 6'd10, 32'h1234_5678, 32'h9, 0);
    @(negedge clk_i);
    #1 drive(0, 0, 0, 0, 0);
    repeat (15) @(negedge clk_i);
    #1 rst_i = 0;
    #1;
    chk("mrst_ctl", {ready_o, valid_o}, 2'b10);
    chk("mrst_res", result_o, 0);
    chk("mrst_flags", {zero_o, branch_o, illegal_o}, 3'b000);
    repeat (2) @(negedge clk_i);
    #1 rst_i = 1;
    drive(1, 6'd2, 2, 3, 0);
    @(negedge clk_i);
    chk("post_rst_add", {valid_o, result_o}, {1'b1, 32'd5});
    #1 drive(0, 0, 0, 0, 0);

    // Randomised traffic
    for (int i = 0; i < 600; i++) begin
      logic [5:0] c;
      @(negedge clk_i);
      c = ($urandom_range(0, 7) == 0) ? 6'($urandom_range(0, 63)) : 6'($urandom_range(0, 13));
      if (c == 6'd10 && $urandom_range(0, 3) != 0) c = 6'd2;
      #1 drive(($urandom_range(0, 3) != 0), c, rnd_op(), rnd_op(), 5'($urandom));
    end
    #1 drive(0, 0, 0, 0, 0);
    repeat (40) @(negedge clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
